// File: rtl/host_sched_pkg.sv
// -----------------------------------------------------------------------------
// host_sched_pkg
// Shared definitions for the host-bound scheduler path: the default descriptor
// width, the NTS arbiter FSM state encoding and a one-hot helper.
// No ports (package).
// -----------------------------------------------------------------------------
package host_sched_pkg;

    localparam int DESC_W_DFLT = 13;

    // Encoding is visible on ov_arb_state, so the values are fixed.
    typedef enum logic [1:0] {
        SELECT_S  = 2'd0,
        ISSUE_S   = 2'd1,
        CAPTURE_S = 2'd2,
        READY_S   = 2'd3
    } arb_state_e;

    // Up to 16 ports; callers truncate to their own port count.
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'd1 << idx;
    endfunction

endpackage

// File: rtl/nts_rr_pick.sv
// -----------------------------------------------------------------------------
// nts_rr_pick
// Combinational rotate-priority encoder. Finds the first set bit of the
// eligible vector searching upward from iv_ptr+1, wrapping modulo PORT_NUM.
// The port at iv_ptr itself is checked last, so a lone eligible port still wins.
//   iv_eligible  in   PORT_NUM  candidate ports
//   iv_ptr       in   SEL_W     last granted port
//   ov_winner    out  SEL_W     selected port (0 when none found)
//   o_found      out  1         at least one eligible port
// -----------------------------------------------------------------------------
module nts_rr_pick #(
    parameter int PORT_NUM = 8,
    parameter int SEL_W    = 3
) (
    input  logic [PORT_NUM-1:0] iv_eligible,
    input  logic [SEL_W-1:0]    iv_ptr,
    output logic [SEL_W-1:0]    ov_winner,
    output logic                o_found
);

    logic [SEL_W-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest hit is the
    // last assignment and therefore the one that sticks.
    always_comb begin
        ov_winner = '0;
        o_found   = 1'b0;
        idx       = '0;
        for (int i = PORT_NUM; i >= 1; i--) begin
            idx = SEL_W'((int'(iv_ptr) + i) % PORT_NUM);
            if (iv_eligible[idx]) begin
                ov_winner = idx;
                o_found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/host_nts_queue_arbiter.sv
// -----------------------------------------------------------------------------
// host_nts_queue_arbiter
// Round-robin arbiter sharing the host-bound NTS path among PORT_NUM per-port
// descriptor FIFOs. Toward the scheduler it behaves as one FIFO with 1-cycle
// read latency, backed by a single prefetched holding register.
//
// Optional build macro: HOST_NTS_ARB_STAT_EN adds saturating statistics
// counters ov_grant_cnt and ov_underflow_cnt.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   iv_port_enable     per-port eligibility mask (0 = skip)
//   iv_queue_empty     upstream FIFO empty flags
//   ov_queue_rd        one-hot upstream read strobe (only in ISSUE_S)
//   iv_queue_desc      flattened upstream FIFO data, port k at [k*DESC_W +: DESC_W]
//   o_fifo_empty       1 = nothing held for the scheduler
//   i_descriptor_rd    scheduler read strobe
//   ov_descriptor      last delivered descriptor (held between deliveries)
//   ov_last_port       source port of ov_descriptor
//   ov_grant_cnt       (stat build) captures since reset, saturating
//   ov_underflow_cnt   (stat build) ignored scheduler reads, saturating
//   ov_arb_state       current FSM state
// -----------------------------------------------------------------------------
module host_nts_queue_arbiter
    import host_sched_pkg::*;
#(
    parameter int PORT_NUM = 8,
    parameter int DESC_W   = DESC_W_DFLT,
    parameter int SEL_W    = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [PORT_NUM-1:0]        iv_port_enable,
    input  logic [PORT_NUM-1:0]        iv_queue_empty,
    output logic [PORT_NUM-1:0]        ov_queue_rd,
    input  logic [PORT_NUM*DESC_W-1:0] iv_queue_desc,
    output logic                       o_fifo_empty,
    input  logic                       i_descriptor_rd,
    output logic [DESC_W-1:0]          ov_descriptor,
    output logic [SEL_W-1:0]           ov_last_port,
`ifdef HOST_NTS_ARB_STAT_EN
    output logic [15:0]                ov_grant_cnt,
    output logic [15:0]                ov_underflow_cnt,
`endif
    output logic [1:0]                 ov_arb_state
);

    arb_state_e          state_q, state_d;
    logic [PORT_NUM-1:0] rd_q, rd_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [DESC_W-1:0]   hold_desc_q, hold_desc_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DESC_W-1:0]   desc_q, desc_d;
    logic [SEL_W-1:0]    last_q, last_d;

    logic [PORT_NUM-1:0] eligible;
    logic [SEL_W-1:0]    winner;
    logic                found;
    logic [DESC_W-1:0]   cap_desc;

    assign eligible = ~iv_queue_empty & iv_port_enable;
    assign cap_desc = iv_queue_desc[sel_q*DESC_W +: DESC_W];

    nts_rr_pick #(
        .PORT_NUM (PORT_NUM),
        .SEL_W    (SEL_W)
    ) u_pick (
        .iv_eligible (eligible),
        .iv_ptr      (ptr_q),
        .ov_winner   (winner),
        .o_found     (found)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= SELECT_S;
            rd_q         <= '0;
            sel_q        <= '0;
            // Parked on the last port so that port 0 is searched first.
            ptr_q        <= SEL_W'(PORT_NUM - 1);
            hold_desc_q  <= '0;
            hold_valid_q <= 1'b0;
            desc_q       <= '0;
            last_q       <= '0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            hold_desc_q  <= hold_desc_d;
            hold_valid_q <= hold_valid_d;
            desc_q       <= desc_d;
            last_q       <= last_d;
        end
    end

    // The read strobe defaults to 0 every cycle, so it is high only for the
    // single cycle spent in ISSUE_S. Upstream FIFOs are non-show-ahead, hence
    // the extra CAPTURE_S cycle before the data is sampled.
    always_comb begin
        state_d      = state_q;
        rd_d         = '0;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        hold_desc_d  = hold_desc_q;
        hold_valid_d = hold_valid_q;
        desc_d       = desc_q;
        last_d       = last_q;
        case (state_q)
            SELECT_S: begin
                if (found) begin
                    rd_d    = PORT_NUM'(onehot16(4'(winner)));
                    sel_d   = winner;
                    state_d = ISSUE_S;
                end
            end
            ISSUE_S: begin
                state_d = CAPTURE_S;
            end
            CAPTURE_S: begin
                hold_desc_d  = cap_desc;
                ptr_d        = sel_q;
                hold_valid_d = 1'b1;
                state_d      = READY_S;
            end
            READY_S: begin
                if (i_descriptor_rd) begin
                    desc_d       = hold_desc_q;
                    last_d       = sel_q;
                    hold_valid_d = 1'b0;
                    state_d      = SELECT_S;
                end
            end
            default: state_d = SELECT_S;
        endcase
    end

    // The scheduler sees "empty" exactly when nothing is held.
    assign o_fifo_empty  = ~hold_valid_q;
    assign ov_queue_rd   = rd_q;
    assign ov_descriptor = desc_q;
    assign ov_last_port  = last_q;
    assign ov_arb_state  = state_q;

`ifdef HOST_NTS_ARB_STAT_EN
    logic [15:0] grant_cnt_q;
    logic [15:0] underflow_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant_cnt_q     <= '0;
            underflow_cnt_q <= '0;
        end else begin
            if (state_q == CAPTURE_S && grant_cnt_q != 16'hFFFF)
                grant_cnt_q <= grant_cnt_q + 16'd1;
            if (i_descriptor_rd && !hold_valid_q && underflow_cnt_q != 16'hFFFF)
                underflow_cnt_q <= underflow_cnt_q + 16'd1;
        end
    end

    assign ov_grant_cnt     = grant_cnt_q;
    assign ov_underflow_cnt = underflow_cnt_q;
`endif

endmodule

// File: tb/tb_host_nts_queue_arbiter.sv
// Self-checking bench for host_nts_queue_arbiter: upstream FIFOs and a
// delivery-level reference model live in the bench; every cycle the DUT
// outputs are compared against the model, plus literal delivery expectations.
module tb_host_nts_queue_arbiter;

    localparam int PN = 8;
    localparam int DW = 13;
    localparam int SW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PN-1:0]    en = '1;
    logic [PN-1:0]    qempty;
    logic [PN-1:0]    qrd;
    logic [PN*DW-1:0] qdesc;
    logic             fempty;
    logic             drd = 1'b0;
    logic [DW-1:0]    odesc;
    logic [SW-1:0]    olast;
    logic [1:0]       ostate;
`ifdef HOST_NTS_ARB_STAT_EN
    logic [15:0]      gcnt;
    logic [15:0]      ucnt;
`endif

    always #5 clk = ~clk;

    host_nts_queue_arbiter #(.PORT_NUM(PN), .DESC_W(DW), .SEL_W(SW)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .iv_port_enable   (en),
        .iv_queue_empty   (qempty),
        .ov_queue_rd      (qrd),
        .iv_queue_desc    (qdesc),
        .o_fifo_empty     (fempty),
        .i_descriptor_rd  (drd),
        .ov_descriptor    (odesc),
        .ov_last_port     (olast),
`ifdef HOST_NTS_ARB_STAT_EN
        .ov_grant_cnt     (gcnt),
        .ov_underflow_cnt (ucnt),
`endif
        .ov_arb_state     (ostate)
    );

    // Upstream non-show-ahead FIFOs
    logic [DW-1:0] fifo [PN][$];
    logic [DW-1:0] dout [PN];
    logic [PN-1:0] rd_seen = '0;

    // Reference model: a fetch is described by its age in cycles since the
    // winning search; age -1 means searching with nothing held.
    int            m_age = -1;
    int            m_ptr = PN - 1;
    int            m_win = 0;
    logic [DW-1:0] m_hold = '0;
    logic [DW-1:0] m_dout = '0;
    int            m_last = 0;
    int            m_grant = 0;
    int            m_unf = 0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic [SW-1:0] p;
    } obs_t;
    obs_t obs[$];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic refresh();
        for (int k = 0; k < PN; k++) begin
            qdesc[k*DW +: DW] = dout[k];
            qempty[k] = (fifo[k].size() == 0);
        end
    endtask

    task automatic push(input int port, input logic [DW-1:0] d);
        fifo[port].push_back(d);
        refresh();
    endtask

    task automatic model_advance();
        logic [PN-1:0] elig;
        bit found;
        int w;
        if (rst) begin
            m_age = -1; m_ptr = PN - 1; m_win = 0; m_hold = '0;
            m_dout = '0; m_last = 0; m_grant = 0; m_unf = 0;
            return;
        end
        if (drd && m_age < 3 && m_unf < 16'hFFFF) m_unf++;
        if (m_age < 0) begin
            elig  = en & ~qempty;
            found = 0;
            w     = 0;
            for (int i = 1; i <= PN; i++)
                if (!found && elig[(m_ptr + i) % PN]) begin
                    found = 1;
                    w = (m_ptr + i) % PN;
                end
            if (found) begin
                m_win = w; m_ptr = w; m_hold = fifo[w][0]; m_age = 1;
            end
        end else if (m_age < 3) begin
            if (m_age == 2 && m_grant < 16'hFFFF) m_grant++;
            m_age++;
        end else if (drd) begin
            m_dout = m_hold; m_last = m_win; m_age = -1;
        end
    endtask

    task automatic compare();
        logic [PN-1:0] e_rd;
        e_rd = (m_age == 1) ? (PN'(1) << m_win) : '0;
        chk("queue_rd", qrd, e_rd);
        chk("fifo_empty", fempty, (m_age < 3) ? 1 : 0);
        chk("descriptor", odesc, m_dout);
        chk("last_port", olast, m_last);
        chk("arb_state", ostate, (m_age < 0) ? 0 : m_age);
`ifdef HOST_NTS_ARB_STAT_EN
        chk("grant_cnt", gcnt, m_grant);
        chk("underflow_cnt", ucnt, m_unf);
`endif
    endtask

    task automatic step();
        bit took;
        took = drd && !fempty;
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < PN; k++) begin
            if (rst) begin
                fifo[k].delete();
                dout[k] = '0;
            end else if (rd_seen[k] && fifo[k].size() > 0) begin
                dout[k] = fifo[k].pop_front();
            end
        end
        refresh();
        compare();
        rd_seen = qrd;
        if (took) obs.push_back('{cyc, odesc, olast});
    endtask

    task automatic serve(input int target, input int budget);
        int n;
        n = 0;
        while (obs.size() < target && n < budget) begin
            drd = !fempty;
            step();
            n++;
        end
        drd = 1'b0;
        chk("deliveries", obs.size(), target);
    endtask

    task automatic chk_obs(input string nm, input int i, input logic [DW-1:0] d, input logic [SW-1:0] p);
        if (i < obs.size()) begin
            chk({nm, "_desc"}, obs[i].d, d);
            chk({nm, "_port"}, obs[i].p, p);
        end else begin
            chk({nm, "_missing"}, obs.size(), i + 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < PN; k++) dout[k] = '0;
        refresh();

        // Reset state
        do_reset();
        step();
        chk("rst_fifo_empty", fempty, 1);
        chk("rst_queue_rd", qrd, 0);
        chk("rst_state", ostate, 0);
        chk("rst_desc", odesc, 0);
        chk("rst_last", olast, 0);

        // Ports 0, 3, 5 with one descriptor each
        push(0, 13'h011); push(3, 13'h033); push(5, 13'h055);
        obs.delete();
        serve(3, 60);
        chk_obs("t1_0", 0, 13'h011, 0);
        chk_obs("t1_1", 1, 13'h033, 3);
        chk_obs("t1_2", 2, 13'h055, 5);

        // Port 7 only, three descriptors, back-to-back with wrap
        push(7, 13'h100); push(7, 13'h101); push(7, 13'h102);
        obs.delete();
        serve(3, 60);
        chk_obs("t2_0", 0, 13'h100, 7);
        chk_obs("t2_1", 1, 13'h101, 7);
        chk_obs("t2_2", 2, 13'h102, 7);
        if (obs.size() >= 3) begin
            chk("t2_spacing_a", obs[1].cyc - obs[0].cyc, 4);
            chk("t2_spacing_b", obs[2].cyc - obs[1].cyc, 4);
        end

        // Port 2 masked; unmask while port 6's descriptor is held
        en = 8'hFB;
        push(2, 13'h222); push(6, 13'h266);
        obs.delete();
        for (int n = 0; n < 20 && fempty; n++) step();
        chk("t3_held", fempty, 0);
        en = 8'hFF;
        step(); step(); step();
        serve(2, 60);
        chk_obs("t3_0", 0, 13'h266, 6);
        chk_obs("t3_1", 1, 13'h222, 2);

        // Scheduler read with nothing held is ignored
        drd = 1'b1;
        step();
        drd = 1'b0;
        step();
        chk("t4_desc", odesc, 13'h222);
        chk("t4_last", olast, 2);
        chk("t4_empty", fempty, 1);
`ifdef HOST_NTS_ARB_STAT_EN
        chk("t4_underflow", ucnt, 1);
        chk("t4_grants", gcnt, 8);
`endif

        // Randomized traffic, masks and scheduler reads
        for (int n = 0; n < 3000; n++) begin
            int p;
            p = $urandom_range(0, PN - 1);
            if ($urandom_range(0, 3) == 0 && fifo[p].size() < 4)
                push(p, DW'($urandom));
            if ($urandom_range(0, 7) == 0)
                en = ($urandom_range(0, 1) == 0) ? 8'hFF : PN'($urandom);
            drd = ($urandom_range(0, 2) != 0);
            step();
        end
        drd = 1'b0;
        en = 8'hFF;

        // Reset during CAPTURE_S discards the fetch; next fetch starts at port 0
        do_reset();
        step();
        push(3, 13'h333);
        for (int n = 0; n < 10 && ostate != 2'd2; n++) step();
        chk("t5_in_capture", ostate, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_empty", fempty, 1);
        chk("t5_rst_rd", qrd, 0);
        chk("t5_rst_state", ostate, 0);
        chk("t5_rst_desc", odesc, 0);
        chk("t5_rst_last", olast, 0);
        push(0, 13'h0A0); push(5, 13'h0A5);
        obs.delete();
        serve(2, 60);
        chk_obs("t5_0", 0, 13'h0A0, 0);
        chk_obs("t5_1", 1, 13'h0A5, 5);

`ifdef HOST_NTS_ARB_STAT_EN
        // Underflow counter saturation
        do_reset();
        drd = 1'b1;
        for (int n = 0; n < 70000; n++) step();
        drd = 1'b0;
        step();
        chk("t6_underflow_sat", ucnt, 16'hFFFF);
        chk("t6_grants", gcnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
